wb_cdb_arbiter: RTL and testbench
=================================

# wb_cdb_arbiter

Parametrised writeback arbiter between the execute-stage skid-buffer outputs and the dispatch-side consumers (CDB wakeup, PRF write port, ROB completion). It accepts up to NUM_CH functional-unit result channels, selects one per cycle round-robin, and broadcasts it through a registered output stage. A branch mispredict raises a recovery pulse and holds off all channels for a programmable window. This block replaces the constant tie-offs currently on the processor's recover/CDB/PRF/ROB-complete nets.

## Interface
Parameters:
- NUM_CH, 3: number of writeback channels (ALU=0, BR=1, LSU=2 in the default build); at least 2.
- PREG_W, 6: physical register tag width.
- DATA_W, 32: result data width.
- ROB_DEPTH, 16: ROB entries; ROB_IDX_W = $clog2(ROB_DEPTH).
- RECOVER_CYCLES, 2: hold-off cycles after a mispredict; at least 1.
- BR_CH, 1: channel index of the branch unit (used only under the macro).

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: synchronous, active-high reset.
- flush_i, in, 1: discard the current grant and abort recovery.
- wb_valid_i, in, NUM_CH: per-channel result valid.
- wb_ready_o, out, NUM_CH: per-channel accept; one-hot or zero.
- wb_we_i, in, NUM_CH: channel has a destination register.
- wb_mispredict_i, in, NUM_CH: channel result is a mispredicted branch.
- wb_tag_i, in, NUM_CH*PREG_W: packed destination tags, channel 0 in the LSBs.
- wb_data_i, in, NUM_CH*DATA_W: packed results.
- wb_rob_idx_i, in, NUM_CH*ROB_IDX_W: packed ROB indices.
- cdb_valid_o / cdb_tag_o, out, 1 / PREG_W: wakeup broadcast.
- prf_wb_en_o / prf_wb_addr_o / prf_wb_data_o, out, 1 / PREG_W / DATA_W: PRF write.
- rob_complete_valid_o / rob_complete_idx_o / rob_complete_mispredict_o, out, 1 / ROB_IDX_W / 1: ROB completion.
- recover_o, out, 1: one-cycle recovery pulse.
- busy_o, out, 1: high while in RECOVER.

## Operation
- FSM states:
  - ARB: arbitrate.
  - RECOVER: all wb_ready_o are 0; a down-counter is loaded with RECOVER_CYCLES.
- Round-robin pointer rr_ptr names the highest-priority channel. The grant goes to the first valid channel scanning rr_ptr, rr_ptr+1, … modulo NUM_CH.
- After a grant to channel g, rr_ptr becomes (g+1) mod NUM_CH. Wrap from NUM_CH-1 goes to 0.
- rr_ptr is unchanged when there is no grant.
- wb_ready_o[g] = 1 only for the granted channel, only in ARB, and only when flush_i = 0. A transfer is valid && ready.
- Output stage, registered from the transfer:
  - rob_complete_valid_o = 1.
  - cdb_valid_o = prf_wb_en_o = wb_we_i[g].
  - tag, data, idx and mispredict are copied from channel g.
  - recover_o = wb_mispredict_i[g].
  - With no transfer, all valid/enable outputs are 0. Payload outputs hold their last value.
- A granted mispredict moves ARB to RECOVER.
- In RECOVER the counter decrements every cycle. When the counter is 1, the next state is ARB.
- flush_i in any state: no grant that cycle, next state ARB, counter cleared, rr_ptr unchanged.
- flush_i has priority over a simultaneous mispredict. The output stage still registers nothing that cycle, because no transfer occurs.
- Reset:
  - State ARB, rr_ptr = 0, counter = 0.
  - All outputs 0, including payloads. busy_o = 0.
  - A reset mid-RECOVER returns the block to ARB on the next cycle.

## Timing
- Grant is combinational in cycle N from wb_valid_i, state, rr_ptr and flush_i. wb_ready_o may depend on wb_valid_i; upstream skid buffers tolerate this.
- Latency: a transfer in cycle N appears on all output buses in cycle N+1, for exactly one cycle.
- Throughput: one result per cycle when any channel is valid in ARB.
- Mispredict transferred in cycle N:
  - recover_o and rob_complete_mispredict_o are high in N+1.
  - busy_o is high and all ready are 0 for cycles N+1 … N+RECOVER_CYCLES.
  - First new grant is possible in N+RECOVER_CYCLES+1.
- Outputs are never back-pressured; consumers must accept every cycle.

## Configuration
- WB_ARB_BR_PRIO_EN defined: channel BR_CH wins whenever wb_valid_i[BR_CH] = 1, regardless of rr_ptr. rr_ptr does not advance on a BR_CH grant. The other channels keep round-robin among themselves.
- Undefined: pure round-robin over all channels, BR_CH ignored.

## Test plan
- Reset, then idle: all outputs 0, busy_o 0, wb_ready_o = 3'b000 for 4 cycles.
- Channels 0, 1 and 2 all valid continuously with wb_we_i = 3'b111, macro off: grants 0,1,2,0,1,2. Each cdb_tag_o matches the granted tag one cycle later with cdb_valid_o high every cycle.
- Channel 1 alone, wb_we_i[1] = 0, rob_idx = 5: ready[1] high; next cycle rob_complete_valid_o = 1 and idx = 5, while cdb_valid_o = 0 and prf_wb_en_o = 0.
- Channel 1 mispredict with rob_idx = 15 (wrap entry), RECOVER_CYCLES = 2, channels 0 and 2 held valid:
  - recover_o pulses at N+1; busy_o is high at N+1 and N+2; ready is 0 there.
  - Channel 2 is granted at N+3.
- Mispredict grant attempted with flush_i = 1 in the same cycle: no ready, no recover_o, state stays ARB. Flush asserted mid-RECOVER: busy_o drops the following cycle.
- Macro on, all channels valid: channel 1 is granted every cycle while valid. On deasserting it, channels 0 and 2 alternate starting from 0.

Source files
------------

// File: rtl/wb_cdb_arbiter.sv
// Round-robin writeback arbiter feeding CDB, PRF write and ROB completion.
// Optional WB_ARB_BR_PRIO_EN: channel BR_CH always wins when valid.
module wb_cdb_arbiter #(
  parameter int NUM_CH         = 3,
  parameter int PREG_W         = 6,
  parameter int DATA_W         = 32,
  parameter int ROB_DEPTH      = 16,
  parameter int RECOVER_CYCLES = 2,
  parameter int BR_CH          = 1,
  localparam int ROB_IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic [NUM_CH-1:0]           wb_valid_i,
  output logic [NUM_CH-1:0]           wb_ready_o,
  input  logic [NUM_CH-1:0]           wb_we_i,
  input  logic [NUM_CH-1:0]           wb_mispredict_i,
  input  logic [NUM_CH*PREG_W-1:0]    wb_tag_i,
  input  logic [NUM_CH*DATA_W-1:0]    wb_data_i,
  input  logic [NUM_CH*ROB_IDX_W-1:0] wb_rob_idx_i,
  output logic                        cdb_valid_o,
  output logic [PREG_W-1:0]           cdb_tag_o,
  output logic                        prf_wb_en_o,
  output logic [PREG_W-1:0]           prf_wb_addr_o,
  output logic [DATA_W-1:0]           prf_wb_data_o,
  output logic                        rob_complete_valid_o,
  output logic [ROB_IDX_W-1:0]        rob_complete_idx_o,
  output logic                        rob_complete_mispredict_o,
  output logic                        recover_o,
  output logic                        busy_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic {
    ARB,
    RECOVER
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic             gnt_vld;
  logic [CH_W-1:0]  gnt_idx;
  logic             xfer;
  logic             gnt_mp;

  logic                 cdb_valid_q, cdb_valid_d;
  logic                 prf_en_q, prf_en_d;
  logic                 rob_valid_q, rob_valid_d;
  logic                 recover_q, recover_d;
  logic                 mp_q, mp_d;
  logic [PREG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [ROB_IDX_W-1:0] idx_q, idx_d;

  // First valid channel scanning from rr_ptr upward, modulo NUM_CH
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef WB_ARB_BR_PRIO_EN
    if (wb_valid_i[BR_CH]) begin
      gnt_vld = 1'b1;
      gnt_idx = CH_W'(BR_CH);
    end
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_vld &&
          wb_valid_i[(int'(rr_ptr_q) + i) % NUM_CH]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      end
    end
  end

  assign xfer   = gnt_vld && (state_q == ARB) && !flush_i;
  assign gnt_mp = wb_mispredict_i[gnt_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (gnt_idx == CH_W'(NUM_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + 1'b1;
      end
`ifdef WB_ARB_BR_PRIO_EN
      if (gnt_idx == CH_W'(BR_CH)) begin
        rr_ptr_d = rr_ptr_q;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ARB;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = ARB;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ARB: begin
          if (xfer && gnt_mp) begin
            state_d = RECOVER;
            cnt_d   = CNT_W'(RECOVER_CYCLES);
          end
        end
        RECOVER: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ARB;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    wb_ready_o = '0;
    if (xfer) begin
      wb_ready_o[gnt_idx] = 1'b1;
    end
    busy_o = (state_q == RECOVER);
  end

  // Payloads hold their last value when nothing transfers
  always_comb begin
    cdb_valid_d = 1'b0;
    prf_en_d    = 1'b0;
    rob_valid_d = 1'b0;
    recover_d   = 1'b0;
    mp_d        = mp_q;
    tag_d       = tag_q;
    data_d      = data_q;
    idx_d       = idx_q;
    if (xfer) begin
      cdb_valid_d = wb_we_i[gnt_idx];
      prf_en_d    = wb_we_i[gnt_idx];
      rob_valid_d = 1'b1;
      recover_d   = gnt_mp;
      mp_d        = gnt_mp;
      tag_d       = wb_tag_i[gnt_idx*PREG_W +: PREG_W];
      data_d      = wb_data_i[gnt_idx*DATA_W +: DATA_W];
      idx_d       = wb_rob_idx_i[gnt_idx*ROB_IDX_W +: ROB_IDX_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cdb_valid_q <= 1'b0;
      prf_en_q    <= 1'b0;
      rob_valid_q <= 1'b0;
      recover_q   <= 1'b0;
      mp_q        <= 1'b0;
      tag_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      prf_en_q    <= prf_en_d;
      rob_valid_q <= rob_valid_d;
      recover_q   <= recover_d;
      mp_q        <= mp_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
    end
  end

  assign cdb_valid_o               = cdb_valid_q;
  assign cdb_tag_o                 = tag_q;
  assign prf_wb_en_o               = prf_en_q;
  assign prf_wb_addr_o             = tag_q;
  assign prf_wb_data_o             = data_q;
  assign rob_complete_valid_o      = rob_valid_q;
  assign rob_complete_idx_o        = idx_q;
  assign rob_complete_mispredict_o = mp_q;
  assign recover_o                 = recover_q;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Scoreboard bench for wb_cdb_arbiter (default 3-channel build).
// Expected grants are fixed per scenario; payloads are random per cycle.
module tb_wb_cdb_arbiter;

  localparam int NC = 3;
  localparam int PW = 6;
  localparam int DW = 32;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              flush_i;
  logic [NC-1:0]     wb_valid_i;
  logic [NC-1:0]     wb_ready_o;
  logic [NC-1:0]     wb_we_i;
  logic [NC-1:0]     wb_mispredict_i;
  logic [NC*PW-1:0]  wb_tag_i;
  logic [NC*DW-1:0]  wb_data_i;
  logic [NC*IW-1:0]  wb_rob_idx_i;
  logic              cdb_valid_o;
  logic [PW-1:0]     cdb_tag_o;
  logic              prf_wb_en_o;
  logic [PW-1:0]     prf_wb_addr_o;
  logic [DW-1:0]     prf_wb_data_o;
  logic              rob_complete_valid_o;
  logic [IW-1:0]     rob_complete_idx_o;
  logic              rob_complete_mispredict_o;
  logic              recover_o;
  logic              busy_o;

  wb_cdb_arbiter dut (
    .clk_i                    (clk),
    .reset_i                  (reset_i),
    .flush_i                  (flush_i),
    .wb_valid_i               (wb_valid_i),
    .wb_ready_o               (wb_ready_o),
    .wb_we_i                  (wb_we_i),
    .wb_mispredict_i          (wb_mispredict_i),
    .wb_tag_i                 (wb_tag_i),
    .wb_data_i                (wb_data_i),
    .wb_rob_idx_i             (wb_rob_idx_i),
    .cdb_valid_o              (cdb_valid_o),
    .cdb_tag_o                (cdb_tag_o),
    .prf_wb_en_o              (prf_wb_en_o),
    .prf_wb_addr_o            (prf_wb_addr_o),
    .prf_wb_data_o            (prf_wb_data_o),
    .rob_complete_valid_o     (rob_complete_valid_o),
    .rob_complete_idx_o       (rob_complete_idx_o),
    .rob_complete_mispredict_o(rob_complete_mispredict_o),
    .recover_o                (recover_o),
    .busy_o                   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] tag;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          we;
    logic          mp;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string t,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  // One cycle: drive, check ready/busy, push, clock, pop/compare
  task automatic cyc(input logic [NC-1:0] v,
                     input logic [NC-1:0] we,
                     input logic [NC-1:0] mp,
                     input logic          fl,
                     input logic [NC-1:0] er,
                     input logic          eb,
                     input int            idx1);
    logic [PW-1:0] tg[NC];
    logic [DW-1:0] dt[NC];
    logic [IW-1:0] ix[NC];
    logic          had;
    exp_t          e;
    for (int c = 0; c < NC; c++) begin
      tg[c] = PW'($urandom_range(0, 63));
      dt[c] = $urandom;
      ix[c] = IW'($urandom_range(0, 15));
    end
    if (idx1 >= 0) ix[1] = idx1[IW-1:0];
    for (int c = 0; c < NC; c++) begin
      wb_tag_i[c*PW +: PW]     = tg[c];
      wb_data_i[c*DW +: DW]    = dt[c];
      wb_rob_idx_i[c*IW +: IW] = ix[c];
    end
    wb_valid_i      = v;
    wb_we_i         = we;
    wb_mispredict_i = mp;
    flush_i         = fl;
    #1;
    chk("ready", 64'(wb_ready_o), 64'(er));
    chk("busy", 64'(busy_o), 64'(eb));
    had = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (er[c] && v[c]) begin
        e.tag  = tg[c];
        e.data = dt[c];
        e.idx  = ix[c];
        e.we   = we[c];
        e.mp   = mp[c];
        sb.push_back(e);
        had = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (had && sb.size() > 0) begin
      e = sb.pop_front();
      chk("valids",
          64'({cdb_valid_o, prf_wb_en_o, rob_complete_valid_o}),
          64'({e.we, e.we, 1'b1}));
      chk("cdb_tag", 64'(cdb_tag_o), 64'(e.tag));
      chk("prf_addr", 64'(prf_wb_addr_o), 64'(e.tag));
      chk("prf_data", 64'(prf_wb_data_o), 64'(e.data));
      chk("rob_idx", 64'(rob_complete_idx_o), 64'(e.idx));
      chk("rob_mp", 64'(rob_complete_mispredict_o), 64'(e.mp));
      chk("recover", 64'(recover_o), 64'(e.mp));
    end else begin
      chk("idle_out",
          64'({cdb_valid_o, prf_wb_en_o,
               rob_complete_valid_o, recover_o}),
          64'(0));
    end
  endtask

  task automatic chk_reset_outs(input string t);
    chk(t,
        64'({cdb_valid_o, cdb_tag_o, prf_wb_en_o, prf_wb_addr_o,
             prf_wb_data_o, rob_complete_valid_o, rob_complete_idx_o,
             rob_complete_mispredict_o, recover_o}),
        64'(0));
    chk({t, "_busy"}, 64'(busy_o), 64'(0));
    chk({t, "_ready"}, 64'(wb_ready_o), 64'(0));
  endtask

  initial begin
    reset_i         = 1'b1;
    flush_i         = 1'b0;
    wb_valid_i      = '0;
    wb_we_i         = '0;
    wb_mispredict_i = '0;
    wb_tag_i        = '0;
    wb_data_i       = '0;
    wb_rob_idx_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    #1;
    chk_reset_outs("reset");

    repeat (4) cyc(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, -1);

`ifndef WB_ARB_BR_PRIO_EN
    for (int k = 0; k < 6; k++) begin
      logic [NC-1:0] g;
      g = 3'b001 << (k % 3);
      cyc(3'b111, 3'b111, 3'b000, 1'b0, g, 1'b0, -1);
    end

    cyc(3'b010, 3'b000, 3'b000, 1'b0, 3'b010, 1'b0, 5);

    cyc(3'b100, 3'b111, 3'b000, 1'b0, 3'b100, 1'b0, -1);
    cyc(3'b001, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, -1);
    cyc(3'b111, 3'b111, 3'b010, 1'b0, 3'b010, 1'b0, 15);
    cyc(3'b101, 3'b111, 3'b000, 1'b0, 3'b000, 1'b1, -1);
    cyc(3'b101, 3'b111, 3'b000, 1'b0, 3'b000, 1'b1, -1);
    cyc(3'b101, 3'b111, 3'b000, 1'b0, 3'b100, 1'b0, -1);

    cyc(3'b010, 3'b010, 3'b010, 1'b1, 3'b000, 1'b0, -1);
    cyc(3'b010, 3'b010, 3'b000, 1'b0, 3'b010, 1'b0, -1);

    cyc(3'b010, 3'b010, 3'b010, 1'b0, 3'b010, 1'b0, -1);
    cyc(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, -1);
    cyc(3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, -1);
    cyc(3'b001, 3'b001, 3'b000, 1'b0, 3'b001, 1'b0, -1);

    cyc(3'b010, 3'b010, 3'b010, 1'b0, 3'b010, 1'b0, -1);
    wb_valid_i      = '0;
    wb_mispredict_i = '0;
    reset_i         = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    #1;
    chk_reset_outs("reset_mid_recover");
    cyc(3'b111, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, -1);
`else
    repeat (3) cyc(3'b111, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, -1);
    cyc(3'b101, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, -1);
    cyc(3'b101, 3'b111, 3'b000, 1'b0, 3'b100, 1'b0, -1);
    cyc(3'b101, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, -1);
`endif

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
